// File: rtl/wb_pkg.sv
// Shared defaults and helper for the write-back arbiter slice.
// The requester-index width is derived from the requester count.
package wb_pkg;

    localparam int NREQ_DEF       = 3;
    localparam int REGS_NUM_DEF   = 32;
    localparam int REGS_WIDTH_DEF = 32;
    localparam int ADDR_W_DEF     = $clog2(REGS_NUM_DEF);
    localparam int REQ_IDX_W      = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    // Index width that stays legal when the count collapses to one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr.sv
// Round-robin grant: first valid requester at or above the pointer wins,
// otherwise the search wraps to the lowest-index valid requester.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] hi_valid;
    logic [N-1:0] pick_src;

    for (genvar i = 0; i < N; i++) begin : g_mask
        assign hi_mask[i] = (PTR_W'(i) >= ptr);
    end

    assign hi_valid = valid & hi_mask;
    assign pick_src = (|hi_valid) ? hi_valid : valid;
    // Isolate the lowest set bit of the chosen candidate set.
    assign grant    = pick_src & (~pick_src + N'(1));

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin selection among requesters, a one-cycle
// registered register-file write port and a pending-write scoreboard.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NREQ       = NREQ_DEF,
    parameter int REGS_NUM   = REGS_NUM_DEF,
    parameter int REGS_WIDTH = REGS_WIDTH_DEF,
    localparam int ADDR_W    = idx_w(REGS_NUM),
    localparam int IDX_W     = idx_w(NREQ)
) (
    input  logic                       clk,
    input  logic                       arstn,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*ADDR_W-1:0]     req_addr,
    input  logic [NREQ*REGS_WIDTH-1:0] req_data,
    input  logic                       rsv_valid,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [REGS_WIDTH-1:0]      rf_wdata,
    output logic [REGS_NUM-1:0]        busy,
    output logic [IDX_W-1:0]           grant_id
);

    logic [ADDR_W-1:0]     addr_arr [NREQ];
    logic [REGS_WIDTH-1:0] data_arr [NREQ];

    logic [NREQ-1:0]       grant;
    logic [IDX_W-1:0]      grant_idx;
    logic [ADDR_W-1:0]     sel_addr;
    logic [REGS_WIDTH-1:0] sel_data;
    logic                  xfer;

    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     waddr_q, waddr_d;
    logic [REGS_WIDTH-1:0] wdata_q, wdata_d;
    logic [IDX_W-1:0]      gid_q, gid_d;
    logic [REGS_NUM-1:0]   busy_q, busy_d;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_arr[i] = req_data[i*REGS_WIDTH +: REGS_WIDTH];
    end

    rr_arbiter #(
        .N     (NREQ),
        .PTR_W (IDX_W)
    ) u_rr (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // Gating with arstn keeps requesters from seeing a handshake during reset.
    assign req_ready = grant & {NREQ{arstn}};
    assign xfer      = |req_ready;

    always_comb begin
        grant_idx = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
                sel_addr  = addr_arr[i];
                sel_data  = data_arr[i];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Register-0 writes are accepted but dropped; the port holds its last value.
    always_comb begin
        we_d    = xfer && (sel_addr != '0);
        waddr_d = we_d ? sel_addr : waddr_q;
        wdata_d = we_d ? sel_data : wdata_q;
        gid_d   = xfer ? grant_idx : gid_q;
    end

    // Reservation is applied after the clear so a same-edge set wins.
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ptr_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            gid_q   <= '0;
            busy_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
        end
    end

    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign grant_id = gid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: fixed vectors with hand-derived expectations.
module tb_wb_arbiter;

    logic        clk;
    logic        arstn;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
    logic [1:0]  grant_id;

    logic [4:0]  a [3];
    logic [31:0] d [3];

    int n_cmp = 0;
    int n_bad = 0;

    assign req_addr = {a[2], a[1], a[0]};
    assign req_data = {d[2], d[1], d[0]};

    wb_arbiter dut (
        .clk       (clk),
        .arstn     (arstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        arstn = 1'b0;
        req_valid = 3'b111;
        rsv_valid = 1'b0;
        rsv_addr = '0;
        for (int i = 0; i < 3; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
        #12;
        n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL rst_ready got %b want 000", req_ready); end
        n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL rst_we got %b want 0", rf_we); end
        n_cmp++; if (busy !== 32'h0) begin n_bad++; $display("FAIL rst_busy got %h want 0", busy); end
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_gid got %0d want 0", grant_id); end
        n_cmp++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_port got %0d/%h want 0/0", rf_waddr, rf_wdata); end
        req_valid = 3'b000;
        arstn = 1'b1;
        tick;
    endtask

    task automatic test_round_robin;
        logic [31:0] dv [3];
        logic [2:0]  exp_rdy;
        int g;
        dv[0] = 32'hAAAA_0001;
        dv[1] = 32'hBBBB_0002;
        dv[2] = 32'hCCCC_0003;
        for (int i = 0; i < 3; i++) begin
            a[i] = 5'(i + 1);
            d[i] = dv[i];
        end
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            g = k % 3;
            exp_rdy = 3'b001 << g;
            #1;
            n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, exp_rdy); end
            tick;
            n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'(g + 1) || rf_wdata !== dv[g]) begin
                n_bad++; $display("FAIL rr_write[%0d] got we=%b r%0d=%h want we=1 r%0d=%h", k, rf_we, rf_waddr, rf_wdata, g + 1, dv[g]);
            end
            n_cmp++; if (grant_id !== 2'(g)) begin n_bad++; $display("FAIL rr_gid[%0d] got %0d want %0d", k, grant_id, g); end
        end
        req_valid = 3'b000;
        #1;
        n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL idle_ready got %b want 000", req_ready); end
        tick;
        n_cmp++; if (rf_we !== 1'b0 || rf_waddr !== 5'd3 || rf_wdata !== dv[2]) begin
            n_bad++; $display("FAIL idle_hold got we=%b r%0d=%h want we=0 r3=%h", rf_we, rf_waddr, rf_wdata, dv[2]);
        end
    endtask

    task automatic test_scoreboard;
        rsv_valid = 1'b1;
        rsv_addr = 5'd5;
        tick;
        rsv_valid = 1'b0;
        for (int e = 0; e < 3; e++) begin
            n_cmp++; if (busy[5] !== 1'b1) begin n_bad++; $display("FAIL sb_busy_edge%0d got %b want 1", e, busy[5]); end
            if (e < 2) tick;
        end
        req_valid = 3'b010;
        a[1] = 5'd5;
        d[1] = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL sb_ready got %b want 010", req_ready); end
        tick;
        req_valid = 3'b000;
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL sb_write got we=%b r%0d=%h want we=1 r5=deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        n_cmp++; if (busy[5] !== 1'b1) begin n_bad++; $display("FAIL sb_busy_edge3 got %b want 1", busy[5]); end
        tick;
        n_cmp++; if (busy !== 32'h0) begin n_bad++; $display("FAIL sb_clear got %h want 0", busy); end
        n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL sb_we_after got %b want 0", rf_we); end
    endtask

    task automatic test_reg0;
        rsv_valid = 1'b1;
        rsv_addr = 5'd9;
        tick;
        rsv_valid = 1'b0;
        n_cmp++; if (busy !== 32'h0000_0200) begin n_bad++; $display("FAIL r0_pre_busy got %h want 00000200", busy); end
        req_valid = 3'b001;
        a[0] = 5'd0;
        d[0] = 32'h0000_1234;
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL r0_ready got %b want 001", req_ready); end
        tick;
        req_valid = 3'b000;
        n_cmp++; if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL r0_port got we=%b r%0d=%h want we=0 r5=deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL r0_gid got %0d want 0", grant_id); end
        n_cmp++; if (busy !== 32'h0000_0200) begin n_bad++; $display("FAIL r0_busy got %h want 00000200", busy); end
        tick;
        n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL r0_we_late got %b want 0", rf_we); end
    endtask

    task automatic test_set_clear;
        req_valid = 3'b010;
        a[1] = 5'd7;
        d[1] = 32'h0000_0077;
        #1;
        n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL sc_ready1 got %b want 010", req_ready); end
        tick;
        req_valid = 3'b000;
        rsv_valid = 1'b1;
        rsv_addr = 5'd7;
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin n_bad++; $display("FAIL sc_write7 got we=%b r%0d want we=1 r7", rf_we, rf_waddr); end
        tick;
        rsv_valid = 1'b0;
        n_cmp++; if (busy !== 32'h0000_0280) begin n_bad++; $display("FAIL sc_set_wins got %h want 00000280", busy); end
        req_valid = 3'b100;
        a[2] = 5'd9;
        d[2] = 32'h0000_0099;
        #1;
        n_cmp++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL sc_ready2 got %b want 100", req_ready); end
        tick;
        req_valid = 3'b000;
        tick;
        n_cmp++; if (busy !== 32'h0000_0080) begin n_bad++; $display("FAIL sc_clear9 got %h want 00000080", busy); end
        rsv_valid = 1'b1;
        rsv_addr = 5'd7;
        tick;
        rsv_valid = 1'b0;
        n_cmp++; if (busy !== 32'h0000_0080) begin n_bad++; $display("FAIL sc_rersv got %h want 00000080", busy); end
        req_valid = 3'b001;
        a[0] = 5'd7;
        d[0] = 32'h0000_0707;
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL sc_ready3 got %b want 001", req_ready); end
        tick;
        req_valid = 3'b000;
        tick;
        n_cmp++; if (busy !== 32'h0) begin n_bad++; $display("FAIL sc_no_count got %h want 0", busy); end
    endtask

    task automatic test_reset_mid;
        req_valid = 3'b111;
        a[1] = 5'd4;
        d[1] = 32'h0000_0044;
        rsv_valid = 1'b1;
        rsv_addr = 5'd6;
        #1;
        n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL rm_ready got %b want 010", req_ready); end
        tick;
        rsv_valid = 1'b0;
        n_cmp++; if (rf_we !== 1'b1 || busy !== 32'h0000_0040) begin n_bad++; $display("FAIL rm_pre got we=%b busy=%h want we=1 busy=00000040", rf_we, busy); end
        arstn = 1'b0;
        #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL rm_we got %b want 0", rf_we); end
        n_cmp++; if (busy !== 32'h0) begin n_bad++; $display("FAIL rm_busy got %h want 0", busy); end
        n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL rm_ready_rst got %b want 000", req_ready); end
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL rm_gid got %0d want 0", grant_id); end
        #2;
        arstn = 1'b1;
        req_valid = 3'b101;
        a[0] = 5'd10;
        d[0] = 32'h0000_0A0A;
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL rm_first got %b want 001", req_ready); end
        n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL rm_no_we got %b want 0", rf_we); end
        tick;
        req_valid = 3'b000;
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'h0000_0A0A) begin
            n_bad++; $display("FAIL rm_write got we=%b r%0d=%h want we=1 r10=00000a0a", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_rr_pointer;
        req_valid = 3'b100;
        a[2] = 5'd11;
        d[2] = 32'h0000_0B0B;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL rp_only2[%0d] got %b want 100", k, req_ready); end
            tick;
        end
        req_valid = 3'b110;
        a[1] = 5'd12;
        d[1] = 32'h0000_0C0C;
        #1;
        n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL rp_wrap got %b want 010", req_ready); end
        tick;
        n_cmp++; if (grant_id !== 2'd1 || rf_waddr !== 5'd12) begin n_bad++; $display("FAIL rp_gid1 got %0d r%0d want 1 r12", grant_id, rf_waddr); end
        #1;
        n_cmp++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL rp_next got %b want 100", req_ready); end
        tick;
        req_valid = 3'b000;
        n_cmp++; if (grant_id !== 2'd2 || rf_waddr !== 5'd11) begin n_bad++; $display("FAIL rp_gid2 got %0d r%0d want 2 r11", grant_id, rf_waddr); end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_scoreboard;
        test_reg0;
        test_set_clear;
        test_reset_mid;
        test_rr_pointer;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
